// File: rtl/onehot_demux_router_pkg.sv
// Shared types and helpers for the one-hot demux router.
// Optional error counter width is used when ONEHOT_DEMUX_ERR_CNT_EN is defined.
package onehot_demux_pkg;

   localparam int unsigned ERR_CNT_W = 8;
   localparam int unsigned MAX_N     = 32;
   localparam int unsigned IDX_MAX_W = $clog2(MAX_N);

   // Exactly one bit set, by population count.
   function automatic logic is_onehot(input logic [MAX_N-1:0] v);
      int unsigned ones;
      ones = 0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         ones = ones + int'(v[i]);
      end
      return (ones == 1);
   endfunction

   function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] v);
      logic [IDX_MAX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (v[i]) idx = IDX_MAX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/onehot_demux_router_if.sv
// Input stream and N output streams of the one-hot demux router.
interface onehot_demux_router_if #(
   parameter int N     = 4,
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_dest;
   logic [WIDTH-1:0] in_data;
   logic [N-1:0]     out_valid;
   logic [N-1:0]     out_ready;
   logic [WIDTH-1:0] out_data [N];

   modport master (
      output in_valid, in_dest, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_dest, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/onehot_demux_router_slot.sv
// One-entry pipe register: accepts a load whenever empty or draining this cycle.
module demux_slot #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data_in,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic             o_can_accept
);
   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   assign o_can_accept = !r_valid || i_out_ready;
   assign o_out_valid  = r_valid;
   assign o_out_data   = r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data_in;
      end else if (i_out_ready) begin
         r_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/onehot_demux_router.sv
// Routes a one-hot tagged stream to N registered output slots; flags malformed beats.
// Define ONEHOT_DEMUX_ERR_CNT_EN to add a saturating err_count output.
module onehot_demux_router
   import onehot_demux_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   onehot_demux_router_if.slave bus,
`ifdef ONEHOT_DEMUX_ERR_CNT_EN
   output logic [ERR_CNT_W-1:0] err_count,
`endif
   output logic                 err_pulse
);
   localparam int IDX_W = $clog2(N);

   logic             w_legal;
   logic [IDX_W-1:0] w_idx;
   logic [N-1:0]     w_can_accept;
   logic [N-1:0]     w_out_valid;
   logic [WIDTH-1:0] w_out_data [N];
   logic             w_bad_hs;
   logic             r_err;

   assign w_legal = is_onehot(MAX_N'(bus.in_dest));
   assign w_idx   = IDX_W'(onehot_to_idx(MAX_N'(bus.in_dest)));

   // Malformed beats are always consumed so they cannot stall the source.
   assign bus.in_ready = w_legal ? w_can_accept[w_idx] : 1'b1;
   assign w_bad_hs     = bus.in_valid && !w_legal;

   for (genvar g = 0; g < N; g++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_load       (bus.in_valid && w_legal && bus.in_dest[g] && w_can_accept[g]),
         .i_data_in    (bus.in_data),
         .o_out_valid  (w_out_valid[g]),
         .i_out_ready  (bus.out_ready[g]),
         .o_out_data   (w_out_data[g]),
         .o_can_accept (w_can_accept[g])
      );
   end

   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= w_bad_hs;
   end

   assign err_pulse = r_err;

`ifdef ONEHOT_DEMUX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] r_err_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_err_count <= '0;
      else if (r_err && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
   end

   assign err_count = r_err_count;
`endif
endmodule

// File: tb/tb_onehot_demux_router.sv
// Self-checking bench for onehot_demux_router: directed scenarios plus randomized traffic vs a queue model.
module tb_onehot_demux_router;
   localparam int N     = 4;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic err_pulse;
`ifdef ONEHOT_DEMUX_ERR_CNT_EN
   logic [7:0] err_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   onehot_demux_router_if #(.N(N), .WIDTH(WIDTH)) bus ();

   onehot_demux_router #(.N(N), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
`ifdef ONEHOT_DEMUX_ERR_CNT_EN
      .err_count (err_count),
`endif
      .err_pulse (err_pulse)
   );

   // Source-side stability: a stalled beat must be held unchanged.
   logic             st_stall = 1'b0;
   logic [N-1:0]     st_dest;
   logic [WIDTH-1:0] st_data;
   always @(negedge clk) begin
      #2;
      if (!rst_n) st_stall = 1'b0;
      else begin
         if (st_stall) begin
            vectors++;
            if (!(bus.in_valid && bus.in_dest === st_dest && bus.in_data === st_data)) begin
               miscompares++;
               $display("FAIL input_stability got v=%b d=%b data=%h want v=1 d=%b data=%h",
                        bus.in_valid, bus.in_dest, bus.in_data, st_dest, st_data);
            end
         end
         st_stall = bus.in_valid && !bus.in_ready;
         st_dest  = bus.in_dest;
         st_data  = bus.in_data;
      end
   end

   task automatic cyc(input logic v, input logic [N-1:0] d, input logic [WIDTH-1:0] dat,
                      input logic [N-1:0] rdy);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_dest   = d;
      bus.in_data   = dat;
      bus.out_ready = rdy;
      #1;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_dest = 4'b0001; bus.in_data = '0; bus.out_ready = '0;
      #3;
      vectors++;
      if (bus.out_valid !== 4'b0000 || err_pulse !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state got ov=%b err=%b rdy=%b want 0000 0 1",
                  bus.out_valid, err_pulse, bus.in_ready);
      end
      for (int unsigned i = 0; i < N; i++) begin
         vectors++;
         if (bus.out_data[i] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data[%0d] got %h want 0", i, bus.out_data[i]);
         end
      end
      @(negedge clk); #3 rst_n = 1'b1;
   endtask

   task automatic test_basic_route();
      cyc(1, 4'b0100, 32'hDEAD_BEEF, 4'b1111);
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL basic_in_ready got %b want 1", bus.in_ready);
      end
      cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (bus.out_valid !== 4'b0100 || bus.out_data[2] !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL basic_route got ov=%b d2=%h want 0100 deadbeef", bus.out_valid, bus.out_data[2]);
      end
      cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (bus.out_valid !== 4'b0000 || bus.out_data[2] !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL basic_drain got ov=%b d2=%h want 0000 deadbeef", bus.out_valid, bus.out_data[2]);
      end
   endtask

   task automatic test_back_to_back();
      for (int j = 1; j <= 8; j++) begin
         cyc(1, 4'b0001, WIDTH'(j), 4'b1111);
         vectors++;
         if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_in_ready[%0d] got %b want 1", j, bus.in_ready);
         end
         if (j > 1) begin
            vectors++;
            if (bus.out_valid[0] !== 1'b1 || bus.out_data[0] !== WIDTH'(j - 1)) begin
               miscompares++;
               $display("FAIL b2b_data[%0d] got v=%b d=%h want 1 %h", j, bus.out_valid[0],
                        bus.out_data[0], WIDTH'(j - 1));
            end
         end
      end
      cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (bus.out_valid !== 4'b0001 || bus.out_data[0] !== 32'd8) begin
         miscompares++;
         $display("FAIL b2b_last got ov=%b d=%h want 0001 8", bus.out_valid, bus.out_data[0]);
      end
      cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (bus.out_valid !== 4'b0000) begin
         miscompares++; $display("FAIL b2b_empty got %b want 0000", bus.out_valid);
      end
   endtask

   task automatic test_backpressure();
      cyc(1, 4'b0010, 32'hAAAA_0001, 4'b1101);
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL bp_accept_a got %b want 1", bus.in_ready);
      end
      for (int j = 0; j < 3; j++) begin
         cyc(1, 4'b0010, 32'hBBBB_0002, 4'b1101);
         vectors++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0010 || bus.out_data[1] !== 32'hAAAA_0001) begin
            miscompares++;
            $display("FAIL bp_stall[%0d] got rdy=%b ov=%b d1=%h want 0 0010 aaaa0001",
                     j, bus.in_ready, bus.out_valid, bus.out_data[1]);
         end
      end
      cyc(1, 4'b0010, 32'hBBBB_0002, 4'b1111);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_data[1] !== 32'hAAAA_0001) begin
         miscompares++;
         $display("FAIL bp_release got rdy=%b d1=%h want 1 aaaa0001", bus.in_ready, bus.out_data[1]);
      end
      cyc(1, 4'b1000, 32'hCCCC_0003, 4'b1111);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 4'b0010 || bus.out_data[1] !== 32'hBBBB_0002) begin
         miscompares++;
         $display("FAIL bp_reload got rdy=%b ov=%b d1=%h want 1 0010 bbbb0002",
                  bus.in_ready, bus.out_valid, bus.out_data[1]);
      end
      cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (bus.out_valid !== 4'b1000 || bus.out_data[3] !== 32'hCCCC_0003) begin
         miscompares++;
         $display("FAIL bp_c_port3 got ov=%b d3=%h want 1000 cccc0003", bus.out_valid, bus.out_data[3]);
      end
      cyc(0, 4'b0000, 32'h0, 4'b1111);
   endtask

   task automatic test_malformed();
      cyc(1, 4'b0001, 32'h0000_0055, 4'b1110);
      cyc(1, 4'b0000, 32'h1111_1111, 4'b1110);
      vectors++;
      if (bus.in_ready !== 1'b1 || err_pulse !== 1'b0 || bus.out_valid !== 4'b0001) begin
         miscompares++;
         $display("FAIL bad_zero got rdy=%b err=%b ov=%b want 1 0 0001", bus.in_ready, err_pulse, bus.out_valid);
      end
      cyc(1, 4'b0110, 32'h2222_2222, 4'b1110);
      vectors++;
      if (bus.in_ready !== 1'b1 || err_pulse !== 1'b1 || bus.out_valid !== 4'b0001 ||
          bus.out_data[0] !== 32'h55) begin
         miscompares++;
         $display("FAIL bad_multi got rdy=%b err=%b ov=%b d0=%h want 1 1 0001 55",
                  bus.in_ready, err_pulse, bus.out_valid, bus.out_data[0]);
      end
      cyc(0, 4'b0000, 32'h0, 4'b1110);
      vectors++;
      if (err_pulse !== 1'b1 || bus.out_valid !== 4'b0001) begin
         miscompares++; $display("FAIL bad_second_pulse got err=%b ov=%b want 1 0001", err_pulse, bus.out_valid);
      end
      cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (err_pulse !== 1'b0 || bus.out_valid !== 4'b0001) begin
         miscompares++; $display("FAIL bad_pulse_end got err=%b ov=%b want 0 0001", err_pulse, bus.out_valid);
      end
`ifdef ONEHOT_DEMUX_ERR_CNT_EN
      vectors++;
      if (err_count !== 8'd2) begin
         miscompares++; $display("FAIL bad_count got %0d want 2", err_count);
      end
`endif
      cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (bus.out_valid !== 4'b0000) begin
         miscompares++; $display("FAIL bad_drain got %b want 0000", bus.out_valid);
      end
   endtask

`ifdef ONEHOT_DEMUX_ERR_CNT_EN
   task automatic test_err_saturation();
      // Count seen at the sample of the i-th malformed beat is i (two prior errors).
      for (int i = 1; i <= 300; i++) begin
         cyc(1, 4'b0000, 32'h0, 4'b1111);
         if (i == 100 || i == 255 || i == 257 || i == 300) begin
            vectors++;
            if (err_count !== 8'((i > 255) ? 255 : i)) begin
               miscompares++;
               $display("FAIL sat_count[%0d] got %0d want %0d", i, err_count, (i > 255) ? 255 : i);
            end
         end
      end
      repeat (4) cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (err_count !== 8'd255 || err_pulse !== 1'b0) begin
         miscompares++; $display("FAIL sat_hold got cnt=%0d err=%b want 255 0", err_count, err_pulse);
      end
   endtask
`endif

   task automatic test_async_reset();
      cyc(1, 4'b0001, 32'h0101_0101, 4'b0110);
      cyc(1, 4'b1000, 32'h0808_0808, 4'b0110);
      cyc(1, 4'b0011, 32'h0, 4'b0110);
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 4'b1001 || err_pulse !== 1'b1) begin
         miscompares++; $display("FAIL arst_pre got ov=%b err=%b want 1001 1", bus.out_valid, err_pulse);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.out_valid !== 4'b0000 || err_pulse !== 1'b0 || bus.out_data[3] !== 32'h0) begin
         miscompares++;
         $display("FAIL arst_now got ov=%b err=%b d3=%h want 0000 0 0", bus.out_valid, err_pulse, bus.out_data[3]);
      end
      @(negedge clk); #3 rst_n = 1'b1;
      cyc(1, 4'b1000, 32'h3333_3333, 4'b1111);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 4'b0000) begin
         miscompares++; $display("FAIL arst_accept got rdy=%b ov=%b want 1 0000", bus.in_ready, bus.out_valid);
      end
      cyc(0, 4'b0000, 32'h0, 4'b1111);
      vectors++;
      if (bus.out_valid !== 4'b1000 || bus.out_data[3] !== 32'h3333_3333) begin
         miscompares++;
         $display("FAIL arst_deliver got ov=%b d3=%h want 1000 33333333", bus.out_valid, bus.out_data[3]);
      end
`ifdef ONEHOT_DEMUX_ERR_CNT_EN
      vectors++;
      if (err_count !== 8'd0) begin
         miscompares++; $display("FAIL arst_count got %0d want 0", err_count);
      end
`endif
   endtask

   // Reference model: each port holds a FIFO of beats delivered but not yet taken.
   logic [WIDTH-1:0] q [N][$];

   task automatic test_random();
      logic             v = 1'b0;
      logic [N-1:0]     d = '0;
      logic [WIDTH-1:0] dat = '0;
      logic [N-1:0]     rdy;
      logic             hold = 1'b0;
      logic             exp_err = 1'b0;
      logic             exp_rdy;
      int               exp_cnt = 0;
      int               ones;
      int               k;
      for (int c = 0; c < 3000; c++) begin
         if (!hold) begin
            v   = ($urandom_range(0, 9) < 7);
            dat = $urandom;
            if ($urandom_range(0, 9) < 8) d = N'(1) << $urandom_range(0, N - 1);
            else                          d = N'($urandom);
         end
         for (int i = 0; i < N; i++) rdy[i] = ($urandom_range(0, 9) < 6);
         cyc(v, d, dat, rdy);

         ones = 0; k = 0;
         for (int i = 0; i < N; i++) if (d[i]) begin ones++; k = i; end
         exp_rdy = (ones != 1) || (q[k].size() == 0) || rdy[k];

         vectors++;
         if (bus.in_ready !== exp_rdy) begin
            miscompares++; $display("FAIL rnd_in_ready[%0d] got %b want %b", c, bus.in_ready, exp_rdy);
         end
         vectors++;
         if (err_pulse !== exp_err) begin
            miscompares++; $display("FAIL rnd_err[%0d] got %b want %b", c, err_pulse, exp_err);
         end
`ifdef ONEHOT_DEMUX_ERR_CNT_EN
         vectors++;
         if (err_count !== 8'(exp_cnt)) begin
            miscompares++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, err_count, exp_cnt);
         end
`endif
         for (int i = 0; i < N; i++) begin
            vectors++;
            if (bus.out_valid[i] !== (q[i].size() != 0)) begin
               miscompares++;
               $display("FAIL rnd_valid[%0d][%0d] got %b want %b", c, i, bus.out_valid[i], q[i].size() != 0);
            end else if (q[i].size() != 0 && bus.out_data[i] !== q[i][0]) begin
               miscompares++;
               $display("FAIL rnd_data[%0d][%0d] got %h want %h", c, i, bus.out_data[i], q[i][0]);
            end
         end

         for (int i = 0; i < N; i++) if (q[i].size() != 0 && rdy[i]) void'(q[i].pop_front());
         if (v && exp_rdy && ones == 1) q[k].push_back(dat);
         if (exp_err) exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
         exp_err = v && (ones != 1);
         hold    = v && !exp_rdy;
      end
      cyc(0, '0, '0, '1);
      cyc(0, '0, '0, '1);
   endtask

   initial begin
      test_reset();
      test_basic_route();
      test_back_to_back();
      test_backpressure();
      test_malformed();
`ifdef ONEHOT_DEMUX_ERR_CNT_EN
      test_err_saturation();
`endif
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
